// File: rtl/csa_sched_pkg.sv
// Shared types and defaults for the two-requester time-shared carry-skip adder.
// Holds the scheduler state encoding and the default operand/slice widths.
package csa_sched_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int SLICE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Skip-group size inside the slice: 4-bit groups when they tile evenly, else plain ripple.
    function automatic int skip_block(input int slice);
        return ((slice % 4) == 0) ? 4 : 1;
    endfunction

endpackage

// File: rtl/csa_add_sched_if.sv
// Request/result bundle between two requesters, one consumer and the shared adder.
// master = requesters/consumer side, slave = adder scheduler side.
interface csa_add_sched_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_cin;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_cin;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_cin,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_cin,
        input  req1_ready,
        input  res_valid, res_sum, res_cout, res_id,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_cin,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_cin,
        output req1_ready,
        output res_valid, res_sum, res_cout, res_id,
        input  res_ready
    );

endinterface

// File: rtl/csa_slice.sv
// SLICE-bit carry-skip adder: ripple full adders in BLOCK-bit groups, each group
// bypasses its incoming carry to the next group when every bit propagates.
module csa_slice #(
    parameter int SLICE = 16,
    parameter int BLOCK = 4
) (
    input  logic [SLICE-1:0] a_i,
    input  logic [SLICE-1:0] b_i,
    input  logic             cin_i,
    output logic [SLICE-1:0] sum_o,
    output logic             cout_o
);

    localparam int NBLK = SLICE / BLOCK;

    logic [SLICE-1:0] prop;
    logic [SLICE-1:0] gen;
    logic             carry;
    logic             blk_cin;
    logic             blk_p;
    logic             rip;

    for (genvar gi = 0; gi < SLICE; gi++) begin : g_pg
        assign prop[gi] = a_i[gi] ^ b_i[gi];
        assign gen[gi]  = a_i[gi] & b_i[gi];
    end

    always_comb begin
        sum_o   = '0;
        carry   = cin_i;
        blk_cin = 1'b0;
        blk_p   = 1'b0;
        rip     = 1'b0;
        for (int blk = 0; blk < NBLK; blk++) begin
            blk_cin = carry;
            rip     = carry;
            blk_p   = 1'b1;
            for (int k = 0; k < BLOCK; k++) begin
                sum_o[blk*BLOCK + k] = prop[blk*BLOCK + k] ^ rip;
                rip   = gen[blk*BLOCK + k] | (prop[blk*BLOCK + k] & rip);
                blk_p = blk_p & prop[blk*BLOCK + k];
            end
            // Full-propagate group: the group carry-out equals its carry-in.
            carry = blk_p ? blk_cin : rip;
        end
        cout_o = carry;
    end

endmodule

// File: rtl/csa_add_sched.sv
// Two-requester WIDTH-bit adder built from one SLICE-bit carry-skip slice used twice
// (low half, then high half), with round-robin arbitration and a held result.
module csa_add_sched
    import csa_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SLICE = SLICE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    csa_add_sched_if.slave sched_if
);

    localparam int BLOCK = skip_block(SLICE);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic             id_q;
    logic             last_q;
    logic             carry_q;
    logic [SLICE-1:0] lo_q;
    logic [SLICE-1:0] hi_q;
    logic             cout_q;
    logic             res_valid_q;

    logic             grant0_d;
    logic             grant1_d;
    logic             hs_d;
    logic [SLICE-1:0] slice_a_d;
    logic [SLICE-1:0] slice_b_d;
    logic             slice_cin_d;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;

    // last_q holds the previously granted index; on a tie the other requester wins.
    always_comb begin
        grant0_d = 1'b0;
        grant1_d = 1'b0;
        if (state_q == IDLE) begin
            if (sched_if.req0_valid && sched_if.req1_valid) begin
                grant0_d = last_q;
                grant1_d = ~last_q;
            end else begin
                grant0_d = sched_if.req0_valid;
                grant1_d = sched_if.req1_valid;
            end
        end
    end

    assign hs_d                = grant0_d | grant1_d;
    assign sched_if.req0_ready = grant0_d;
    assign sched_if.req1_ready = grant1_d;

    always_comb begin
        slice_a_d   = a_q[SLICE-1:0];
        slice_b_d   = b_q[SLICE-1:0];
        slice_cin_d = cin_q;
        if (state_q == HI) begin
            slice_a_d   = a_q[WIDTH-1:SLICE];
            slice_b_d   = b_q[WIDTH-1:SLICE];
            slice_cin_d = carry_q;
        end
    end

    csa_slice #(
        .SLICE (SLICE),
        .BLOCK (BLOCK)
    ) u_slice (
        .a_i    (slice_a_d),
        .b_i    (slice_b_d),
        .cin_i  (slice_cin_d),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            carry_q     <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            cout_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs_d) begin
                        a_q     <= grant1_d ? sched_if.req1_a   : sched_if.req0_a;
                        b_q     <= grant1_d ? sched_if.req1_b   : sched_if.req0_b;
                        cin_q   <= grant1_d ? sched_if.req1_cin : sched_if.req0_cin;
                        id_q    <= grant1_d;
                        last_q  <= grant1_d;
                        state_q <= LO;
                    end
                end
                LO: begin
                    lo_q    <= slice_sum;
                    carry_q <= slice_cout;
                    state_q <= HI;
                end
                HI: begin
                    hi_q        <= slice_sum;
                    cout_q      <= slice_cout;
                    res_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (sched_if.res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    res_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign sched_if.res_valid = res_valid_q;
    assign sched_if.res_sum   = {hi_q, lo_q};
    assign sched_if.res_cout  = cout_q;
    assign sched_if.res_id    = id_q;

endmodule

// File: doc/csa_add_sched.md
CSA_ADD_SCHED -- requirements
Module: csa_add_sched

Interface
REQ-001 Parameter: WIDTH, default 32, operand and sum width.
REQ-002 Parameter: SLICE, default 16, width of the shared carry-skip slice; WIDTH SHALL equal 2*SLICE.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset is asynchronous and active-low.
REQ-005 req0_valid  in  1  requester 0 has an operation pending.
REQ-006 req0_ready  out  1  requester 0 operands accepted this cycle.
REQ-007 req0_a, req0_b  in  WIDTH  requester 0 operands.
REQ-008 req0_cin  in  1  requester 0 carry-in.
REQ-009 req1_valid, req1_ready, req1_a, req1_b, req1_cin  same as REQ-005..008, for requester 1.
REQ-010 res_valid  out  1  result available.
REQ-011 res_ready  in  1  consumer accepts result.
REQ-012 res_sum  out  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-013 res_cout  out  1  carry out of bit WIDTH-1.
REQ-014 res_id  out  1  index of the requester that owns the result.

Function
REQ-015 The block SHALL share one SLICE-bit carry-skip adder between two requesters, computing each WIDTH-bit sum in two passes: low half, then high half.
REQ-016 FSM states: IDLE, LO, HI, DONE.
REQ-017 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally in that cycle, capture a, b, cin, and id; go to LO. Otherwise stay in IDLE.
REQ-018 reqN_ready SHALL be 0 in every state except IDLE; at most one ready SHALL be high in any cycle.
REQ-019 Arbitration: round-robin. If both are valid, grant the requester not granted last. The pointer updates only on a handshake.
REQ-020 LO: the slice adds a[SLICE-1:0] + b[SLICE-1:0] + cin; register the low sum and the carry; go to HI.
REQ-021 HI: the slice adds the upper halves plus the registered carry; register the high sum and the cout; go to DONE.
REQ-022 DONE: res_valid = 1; res_sum, res_cout and res_id SHALL stay stable until res_ready = 1. On res_valid & res_ready, go to IDLE.
REQ-023 Latency: a handshake in cycle T gives res_valid = 1 in cycle T+3. Minimum spacing between grants is 4 cycles.
REQ-024 Requester inputs outside IDLE SHALL be ignored. Captured operands SHALL NOT change if requester inputs change later.
REQ-025 res_valid SHALL be 0 in IDLE, LO and HI.
REQ-026 Overflow wraps modulo 2^WIDTH and is reported only through res_cout. No error output.

Reset
REQ-027 Asserting rst_n low at any time, including mid-operation, SHALL immediately force: state IDLE, res_valid 0, res_sum 0, res_cout 0, res_id 0, operand and carry registers 0, round-robin pointer favouring requester 0.
REQ-028 An operation in flight when reset asserts SHALL be discarded and SHALL NOT produce a result.
REQ-029 reqN_ready is combinational from state, and therefore valid from the first cycle after rst_n deasserts.

Structure
REQ-030 Shared package csa_sched_pkg SHALL hold the FSM state enum typedef and the default WIDTH/SLICE constants.
REQ-031 One sub-module: csa_slice, a SLICE-bit carry-skip adder (ripple full adders, group propagate = AND of bit XORs, skip mux on carry-out). The block SHALL instantiate it exactly once.
REQ-032 No other arithmetic unit SHALL be instantiated for the sum.

Verification
REQ-033 Only req0 valid, a=0x0000FFFF, b=0x00000001, cin=0 -> res_valid at T+3, res_sum=0x00010000, res_cout=0, res_id=0.
REQ-034 req1 valid, a=0xFFFFFFFF, b=0x00000000, cin=1 (full-propagate skip path) -> res_sum=0x00000000, res_cout=1, res_id=1.
REQ-035 Both valid continuously with res_ready=1 -> grants alternate 0,1,0,1; each ready pulse lasts 1 cycle; grants are 4 cycles apart.
REQ-036 res_ready held 0 for 5 cycles in DONE while req0 is valid -> result stable, req0_ready stays 0; accept occurs in the cycle after res_ready handshake.
REQ-037 rst_n pulsed low during HI -> next cycle all outputs 0, state IDLE, no result for the discarded op; the next grant goes to requester 0.
REQ-038 Operands changed on req0 inputs during LO/HI -> result reflects the originally captured values.
